// File: rtl/fetch_queue_unit_pkg.sv
// Shared lc3b types for the fetch front end: word, FSM state, queue entry, PC increment.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  localparam int LC3B_LINE_BITS = 128;

  typedef enum logic [1:0] {
    RUN,
    FILL,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    lc3b_word instr;
    lc3b_word pc;
  } fetch_entry_t;

  function automatic lc3b_word plus2(input lc3b_word a);
    return a + 16'd2;
  endfunction

endpackage

// File: rtl/fetch_queue_unit_fifo.sv
// First-word-fall-through FIFO with a registered head, synchronous flush and full-queue pass-through.
module fetch_fifo
  import lc3b_types::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   push,
  input  logic   pop,
  input  entry_t din,
  output entry_t dout,
  output logic   empty,
  output logic   full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_next;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          push_ok;
  logic          pop_ok;
  entry_t        head_next;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // The head register is reloaded from the slot that will be at the front after this
  // edge; when that slot is the one being written now, the incoming entry bypasses memory.
  always_comb begin
    rd_next    = rd_ptr + AW'(pop_ok);
    count_next = count + (AW + 1)'(push_ok) - (AW + 1)'(pop_ok);
    head_next  = dout;
    if (count_next != '0) begin
      if (push_ok && (rd_next == wr_ptr)) begin
        head_next = din;
      end else begin
        head_next = mem[rd_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_next;
      wr_ptr <= wr_ptr + AW'(push_ok);
      count  <= count_next;
      dout   <= head_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// lc3b fetch front end: PC, one-line instruction buffer, line-fill FSM and decode-side fetch queue.
module fetch_queue_unit
  import lc3b_types::*;
#(
  parameter int          LINE_BITS   = LC3B_LINE_BITS,
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [15:0] RESET_PC    = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [15:0]          imem_address,
  output logic                 imem_action_stb,
  output logic                 imem_action_cyc,
  input  logic                 imem_resp,
  input  logic [LINE_BITS-1:0] imem_rdata,
  input  logic                 branch_enable,
  input  logic [15:0]          new_pc,
  input  logic                 decode_ready,
  output logic                 instr_valid,
  output logic [15:0]          instr_out,
  output logic [15:0]          instr_pc,
  output logic [15:0]          pc_plus2_out
);

  localparam int OFF = $clog2(LINE_BITS / 8);

  fetch_state_t         state_q;
  fetch_state_t         state_d;
  lc3b_word             pc_q;
  logic [LINE_BITS-1:0] line_q;
  logic [15:OFF]        line_tag_q;
  logic                 line_valid_q;
  lc3b_word             req_addr_q;
  logic                 stb_q;

  logic                 hit;
  logic                 push;
  logic                 start_fill;
  logic                 capture;
  logic [OFF+2:0]       bit_sel;
  fetch_entry_t         fifo_din;
  fetch_entry_t         head;
  logic                 fifo_empty;
  logic                 fifo_full;

  assign hit     = line_valid_q && (line_tag_q == pc_q[15:OFF]);
  assign bit_sel = {pc_q[OFF-1:1], 4'b0000};

  always_comb begin
    fifo_din       = '0;
    fifo_din.instr = line_q[bit_sel +: 16];
    fifo_din.pc    = pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (!branch_enable && !hit) begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (imem_resp) begin
          state_d = RUN;
        end else if (branch_enable) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_resp) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // A full queue still accepts an entry when decode takes the head in the same cycle.
  always_comb begin
    push       = 1'b0;
    start_fill = 1'b0;
    capture    = 1'b0;
    unique case (state_q)
      RUN: begin
        push       = hit && !branch_enable && (!fifo_full || decode_ready);
        start_fill = !hit && !branch_enable;
      end
      FILL:    capture = imem_resp;
      DRAIN:   capture = 1'b0;
      default: capture = 1'b0;
    endcase
  end

  // The request address is latched at miss time so a redirect during the fill cannot move it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      line_q       <= '0;
      line_tag_q   <= '0;
      line_valid_q <= 1'b0;
      req_addr_q   <= '0;
      stb_q        <= 1'b0;
    end else begin
      stb_q <= (state_d != RUN);
      if (start_fill) begin
        req_addr_q   <= {pc_q[15:OFF], {OFF{1'b0}}};
        line_valid_q <= 1'b0;
      end
      if (capture) begin
        line_q       <= imem_rdata;
        line_tag_q   <= req_addr_q[15:OFF];
        line_valid_q <= 1'b1;
      end
      if (branch_enable) begin
        pc_q <= new_pc & 16'hFFFE;
      end else if (push) begin
        pc_q <= plus2(pc_q);
      end
    end
  end

  fetch_fifo #(
    .DEPTH  (QUEUE_DEPTH),
    .entry_t(fetch_entry_t)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(branch_enable),
    .push (push),
    .pop  (decode_ready),
    .din  (fifo_din),
    .dout (head),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  assign imem_address    = req_addr_q;
  assign imem_action_stb = stb_q;
  assign imem_action_cyc = stb_q;
  assign instr_valid     = !fifo_empty;
  assign instr_out       = head.instr;
  assign instr_pc        = head.pc;
  assign pc_plus2_out    = plus2(head.pc);

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed and randomized checks of fetch_queue_unit against an address-driven stream model.
module tb_fetch_queue_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  imem_address;
  logic         imem_action_stb;
  logic         imem_action_cyc;
  logic         imem_resp;
  logic [127:0] imem_rdata;
  logic         branch_enable;
  logic [15:0]  new_pc;
  logic         decode_ready;
  logic         instr_valid;
  logic [15:0]  instr_out;
  logic [15:0]  instr_pc;
  logic [15:0]  pc_plus2_out;

  always #5 clk = ~clk;

  fetch_queue_unit #(
    .LINE_BITS  (128),
    .QUEUE_DEPTH(4),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_address   (imem_address),
    .imem_action_stb(imem_action_stb),
    .imem_action_cyc(imem_action_cyc),
    .imem_resp      (imem_resp),
    .imem_rdata     (imem_rdata),
    .branch_enable  (branch_enable),
    .new_pc         (new_pc),
    .decode_ready   (decode_ready),
    .instr_valid    (instr_valid),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .pc_plus2_out   (pc_plus2_out)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc_n = 0;
  int          deq_cnt = 0;
  int          t_req = 0;
  int          mem_cnt = 0;
  int          mem_lat = 2;
  bit          rand_lat = 1'b0;
  bit          rst_pending = 1'b0;
  bit          flush_pending = 1'b0;
  logic [15:0] exp_pc = RESET_PC;
  logic [15:0] held_addr = '0;
  logic [15:0] req_q[$];

  // Memory image: the halfword at byte address a holds 0x1000 + a/2.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'h1000 + {1'b0, a[15:1]};
  endfunction

  function automatic logic [127:0] line_of(input logic [15:0] a);
    logic [127:0] l;
    l = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      l[16*k +: 16] = mem_word({a[15:4], 4'b0000} + 16'(2 * k));
    end
    return l;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, update the model, then drive inputs for the next rising edge.
  task automatic step(input logic rdy, input logic br, input logic [15:0] tgt, input logic r);
    logic [15:0] p2;
    @(negedge clk);
    cyc_n++;
    chk("cyc_eq_stb", 32'(imem_action_cyc), 32'(imem_action_stb));
    if (rst_pending) begin
      chk("rst_stb", 32'(imem_action_stb), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", 32'(instr_out), 32'd0);
      chk("rst_pc", 32'(instr_pc), 32'd0);
    end else if (flush_pending) begin
      chk("flush_empty", 32'(instr_valid), 32'd0);
    end
    rst_pending   = r;
    flush_pending = br;
    if (r) begin
      exp_pc = RESET_PC;
    end else begin
      if (instr_valid && rdy) begin
        p2 = exp_pc + 16'd2;
        chk("head_pc", 32'(instr_pc), 32'(exp_pc));
        chk("head_instr", 32'(instr_out), 32'(mem_word(exp_pc)));
        chk("head_pc_plus2", 32'(pc_plus2_out), 32'(p2));
        exp_pc = p2;
        deq_cnt++;
      end
      if (br) exp_pc = tgt & 16'hFFFE;
    end
    if (imem_action_stb === 1'b1) begin
      if (mem_cnt == 0) begin
        req_q.push_back(imem_address);
        held_addr = imem_address;
        t_req = cyc_n;
        if (rand_lat) mem_lat = $urandom_range(0, 4);
        chk("addr_aligned", 32'(imem_address[3:0]), 32'd0);
      end else begin
        chk("addr_hold", 32'(imem_address), 32'(held_addr));
      end
      if (mem_cnt == mem_lat) begin
        imem_resp  = 1'b1;
        imem_rdata = line_of(held_addr);
        mem_cnt    = 0;
      end else begin
        imem_resp  = 1'b0;
        imem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
        mem_cnt++;
      end
    end else begin
      imem_resp  = 1'b0;
      imem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      mem_cnt    = 0;
    end
    rst           = r;
    decode_ready  = rdy;
    branch_enable = br;
    new_pc        = tgt;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    req_q.delete();
    deq_cnt = 0;
  endtask

  initial begin
    rst = 1'b1;
    decode_ready = 1'b0;
    branch_enable = 1'b0;
    new_pc = '0;
    imem_resp = 1'b0;
    imem_rdata = '0;

    // Sequential fetch of line 0 with decode always ready.
    mem_lat = 2;
    do_reset();
    for (int i = 0; i < 50 && !instr_valid; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t1_valid", 32'(instr_valid), 32'd1);
    chk("t1_latency", 32'(cyc_n - t_req), 32'd4);
    for (int i = 0; i < 50 && deq_cnt < 8; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t1_deq8", 32'(deq_cnt), 32'd8);
    for (int i = 0; i < 50 && req_q.size() < 2; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t1_req_count", 32'(req_q.size()), 32'd2);
    chk("t1_req0", 32'(req_q[0]), 32'h0000);
    chk("t1_req1", 32'(req_q[1]), 32'h0010);

    // Decode stalled: the queue fills and the PC stalls inside line 0.
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
    chk("t2_valid", 32'(instr_valid), 32'd1);
    chk("t2_head", 32'(instr_out), 32'h1000);
    chk("t2_no_req", 32'(req_q.size()), 32'd1);
    chk("t2_stb_low", 32'(imem_action_stb), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 16'h0, 1'b0);
      chk("t2_stream_valid", 32'(instr_valid), 32'd1);
    end
    chk("t2_deq8", 32'(deq_cnt), 32'd8);

    // Redirect into the buffered line with three entries queued.
    do_reset();
    for (int i = 0; i < 50 && !instr_valid; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'h0006, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    chk("t3_stb_low0", 32'(imem_action_stb), 32'd0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t3_instr", 32'(instr_out), 32'h1003);
    chk("t3_pc", 32'(instr_pc), 32'h0006);
    chk("t3_plus2", 32'(pc_plus2_out), 32'h0008);
    chk("t3_stb_low1", 32'(imem_action_stb), 32'd0);
    chk("t3_no_req", 32'(req_q.size()), 32'd1);

    // Redirect one cycle into a 4-cycle fill: drain, then refetch at the target.
    mem_lat = 3;
    do_reset();
    step(1'b1, 1'b1, 16'h0020, 1'b0);
    for (int i = 0; i < 20 && req_q.size() < 1; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b1, 16'h0041, 1'b0);
    for (int i = 0; i < 40 && deq_cnt < 4; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t4_deq4", 32'(deq_cnt), 32'd4);
    chk("t4_req_count", 32'(req_q.size()), 32'd2);
    chk("t4_req0", 32'(req_q[0]), 32'h0020);
    chk("t4_req1", 32'(req_q[1]), 32'h0040);

    // Top line of the address space: the PC wraps to zero.
    mem_lat = 1;
    do_reset();
    step(1'b1, 1'b1, 16'hFFF0, 1'b0);
    for (int i = 0; i < 60 && deq_cnt < 9; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t5_deq9", 32'(deq_cnt), 32'd9);
    chk("t5_req_count", 32'(req_q.size()), 32'd2);
    chk("t5_req0", 32'(req_q[0]), 32'hFFF0);
    chk("t5_req1", 32'(req_q[1]), 32'h0000);

    // Reset in the middle of a fill.
    mem_lat = 4;
    do_reset();
    for (int i = 0; i < 20 && req_q.size() < 1; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b1);
    deq_cnt = 0;
    for (int i = 0; i < 40 && deq_cnt < 3; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t6_deq3", 32'(deq_cnt), 32'd3);

    // Random decode stalls, redirects and memory latencies.
    rand_lat = 1'b1;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic        rdy;
      logic        br;
      logic [15:0] tgt;
      rdy = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 1) tgt = exp_pc + 16'($urandom_range(0, 15)) - 16'd8;
      else tgt = 16'($urandom());
      step(rdy, br, tgt, 1'b0);
    end
    chk("rand_progress", 32'(deq_cnt > 200), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
